// File: rtl/bird_controller_pkg.sv
// Shared constants for the bird controller: game-state codes, FSM encoding,
// display geometry and the sprite frame lookup.
package bird_controller_pkg;

   localparam logic [3:0] GS_START = 4'b0001;
   localparam logic [3:0] GS_PLAY  = 4'b0010;
   localparam logic [3:0] GS_PAUSE = 4'b0100;
   localparam logic [3:0] GS_END   = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLY    = 2'd1,
      S_FROZEN = 2'd2,
      S_DEAD   = 2'd3
   } state_t;

   localparam int SCREEN_W     = 640;
   localparam int SCREEN_H     = 480;
   localparam int DISP_FLOOR_Y = 378;

   // Four animation phases map onto the wing-flap sequence 0,1,2,1.
   function automatic logic [2:0] frame_of(input logic [1:0] phase);
      return (phase == 2'd3) ? 3'd1 : {1'b0, phase};
   endfunction

endpackage

// File: rtl/bird_controller_tick_gen.sv
// Free-running divider: pulses tick for one clk every DIV clks.
module tick_gen #(
   parameter int DIV = 833333
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      cnt <= '0;
      else if (tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/bird_controller.sv
// Bird physics, flap capture and sprite animation for the flappy-bird game.
// Optional IDLE hover bobbing is enabled by defining BIRD_HOVER_EN.
module bird_controller
   import bird_controller_pkg::*;
#(
   parameter int TICK_DIV    = 833333,
   parameter int BIRD_X      = 200,
   parameter int START_Y     = 200,
   parameter int BIRD_SIZE_Y = 24,
   parameter int FLOOR_Y     = DISP_FLOOR_Y,
   parameter int GRAVITY     = 1,
   parameter int FLAP_VEL    = 8,
   parameter int MAX_FALL    = 10,
   parameter int ANI_TICKS   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flap,
   input  logic [3:0]  game_state,
   output logic [15:0] birdX,
   output logic [15:0] birdY,
   output logic [2:0]  bird_state,
   output logic        hit,
   output state_t      fsm_state
);

   localparam logic [15:0]        Y_START  = 16'(START_Y);
   localparam logic [15:0]        Y_FLOOR  = 16'(FLOOR_Y - BIRD_SIZE_Y);
   localparam logic signed [8:0]  GRAV_S   = 9'(GRAVITY);
   localparam logic signed [8:0]  MAXF_S   = 9'(MAX_FALL);
   localparam logic signed [7:0]  FLAP_S   = 8'(-FLAP_VEL);
   localparam logic [7:0]         ANI_LAST = 8'(ANI_TICKS - 1);

   state_t             state;
   logic               tick, flap_q, flap_edge, flap_pending;
   logic signed [7:0]  vel, vel_next;
   logic signed [8:0]  vel_grav;
   logic signed [16:0] y_sum;
   logic               y_neg, y_floor;
   logic [7:0]         ani_cnt, ani_cnt_nx;
   logic [1:0]         ani_phase, ani_phase_nx;
   logic               ani_wrap;

`ifdef BIRD_HOVER_EN
   logic signed [3:0]  hover_off, hover_next;
   logic               hover_up;
   assign hover_next = hover_up ? hover_off + 4'sd1 : hover_off - 4'sd1;
`endif

   tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

   assign birdX     = 16'(BIRD_X);
   assign fsm_state = state;
   assign flap_edge = flap & ~flap_q;

   assign ani_wrap     = (ani_cnt == ANI_LAST);
   assign ani_cnt_nx   = ani_wrap ? 8'd0 : ani_cnt + 8'd1;
   assign ani_phase_nx = ani_wrap ? ani_phase + 2'd1 : ani_phase;

   // A flap edge coinciding with the tick counts as a flap on that tick.
   always_comb begin
      vel_grav = $signed({vel[7], vel}) + GRAV_S;
      if (vel_grav > MAXF_S) vel_grav = MAXF_S;
      if (state == S_FLY && (flap_pending || flap_edge)) vel_next = FLAP_S;
      else                                               vel_next = vel_grav[7:0];
      y_sum   = $signed({1'b0, birdY}) + $signed({{9{vel_next[7]}}, vel_next});
      y_neg   = y_sum[16];
      y_floor = !y_sum[16] && (y_sum[15:0] >= Y_FLOOR);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_IDLE;
         birdY        <= Y_START;
         vel          <= '0;
         bird_state   <= '0;
         hit          <= 1'b0;
         flap_q       <= 1'b0;
         flap_pending <= 1'b0;
         ani_cnt      <= '0;
         ani_phase    <= '0;
`ifdef BIRD_HOVER_EN
         hover_off    <= '0;
         hover_up     <= 1'b1;
`endif
      end else begin
         flap_q <= flap;
         hit    <= 1'b0;
         if (tick || state == S_FROZEN) flap_pending <= 1'b0;
         else if (flap_edge)            flap_pending <= 1'b1;

         if (game_state == GS_START && state != S_IDLE) begin
            state      <= S_IDLE;
            birdY      <= Y_START;
            vel        <= '0;
            bird_state <= '0;
            ani_cnt    <= '0;
            ani_phase  <= '0;
`ifdef BIRD_HOVER_EN
            hover_off  <= '0;
            hover_up   <= 1'b1;
`endif
         end else if (game_state == GS_END && state != S_DEAD) begin
            state      <= S_DEAD;
            bird_state <= 3'd1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (game_state == GS_PLAY) state <= S_FLY;
                  else if (tick) begin
                     ani_cnt    <= ani_cnt_nx;
                     ani_phase  <= ani_phase_nx;
                     bird_state <= frame_of(ani_phase_nx);
`ifdef BIRD_HOVER_EN
                     hover_off  <= hover_next;
                     birdY      <= Y_START + 16'(hover_next);
                     if (hover_next == 4'sd4 || hover_next == -4'sd4) hover_up <= ~hover_up;
`endif
                  end
               end
               S_FLY: begin
                  if (game_state == GS_PAUSE) state <= S_FROZEN;
                  else if (tick) begin
                     ani_cnt    <= ani_cnt_nx;
                     ani_phase  <= ani_phase_nx;
                     bird_state <= frame_of(ani_phase_nx);
                     if (y_neg) begin
                        birdY <= '0;
                        vel   <= '0;
                     end else if (y_floor) begin
                        birdY      <= Y_FLOOR;
                        vel        <= vel_next;
                        hit        <= 1'b1;
                        state      <= S_DEAD;
                        bird_state <= 3'd1;
                     end else begin
                        birdY <= y_sum[15:0];
                        vel   <= vel_next;
                     end
                  end
               end
               S_FROZEN: begin
                  if (game_state == GS_PLAY) state <= S_FLY;
               end
               default: begin
                  // Falling corpse: gravity only, settles on the floor silently.
                  bird_state <= 3'd1;
                  if (tick) begin
                     if (y_neg) begin
                        birdY <= '0;
                        vel   <= '0;
                     end else if (y_floor) begin
                        birdY <= Y_FLOOR;
                        vel   <= vel_next;
                     end else begin
                        birdY <= y_sum[15:0];
                        vel   <= vel_next;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule
